// File: rtl/clock_display_mux.sv
// clock_display_mux: six-digit multiplexed 7-segment driver for hh:mm:ss time fields
//   clk         system clock
//   rst         asynchronous active-low reset
//   en          display enable; low blanks the display and freezes the scan
//   sec_in      binary seconds (6 bit)
//   min_in      binary minutes (6 bit)
//   hr_in       binary hours (6 bit)
//   seg         active-low segments {g,f,e,d,c,b,a}
//   dp          active-low decimal point (separator on slots 2 and 4)
//   an          active-low one-hot digit enables, an[i] drives slot i
//   digit_idx   current digit slot 0..5
//   frame_start one-cycle pulse after a new snapshot is taken
module clock_display_mux #(
   parameter int REFRESH_DIV = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [5:0] sec_in,
   input  logic [5:0] min_in,
   input  logic [5:0] hr_in,
   output logic [6:0] seg,
   output logic       dp,
   output logic [5:0] an,
   output logic [2:0] digit_idx,
   output logic       frame_start
);
   logic [15:0] cnt;
   logic [5:0]  snap_sec, snap_min, snap_hr, field;
   logic        slot_tick, valid;
   logic [3:0]  tens, ones, digit;
   logic [6:0]  seg_d;

   function automatic logic [6:0] enc(input logic [3:0] d);
      case (d)
         4'd0:    enc = 7'b1000000;
         4'd1:    enc = 7'b1111001;
         4'd2:    enc = 7'b0100100;
         4'd3:    enc = 7'b0110000;
         4'd4:    enc = 7'b0011001;
         4'd5:    enc = 7'b0010010;
         4'd6:    enc = 7'b0000010;
         4'd7:    enc = 7'b1111000;
         4'd8:    enc = 7'b0000000;
         default: enc = 7'b0010000;
      endcase
   endfunction

   always_comb begin
      slot_tick = en && cnt == 16'(REFRESH_DIV - 1);
      field = digit_idx[2] ? snap_hr : digit_idx[1] ? snap_min : snap_sec;
      valid = field <= (digit_idx[2] ? 6'd23 : 6'd59);
      // constant-compare chain stands in for a divide by ten
      tens = field >= 6'd60 ? 4'd6 : field >= 6'd50 ? 4'd5 : field >= 6'd40 ? 4'd4 :
             field >= 6'd30 ? 4'd3 : field >= 6'd20 ? 4'd2 : field >= 6'd10 ? 4'd1 : 4'd0;
      ones = 4'(field - 6'(tens) * 6'd10);
      digit = digit_idx[0] ? tens : ones;
      seg_d = valid ? enc(digit) : 7'b0111111;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt         <= '0;
         digit_idx   <= '0;
         snap_sec    <= '0;
         snap_min    <= '0;
         snap_hr     <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= slot_tick && digit_idx == 3'd5;
         if (en) cnt <= slot_tick ? '0 : cnt + 16'd1;
         if (slot_tick) digit_idx <= digit_idx == 3'd5 ? 3'd0 : digit_idx + 3'd1;
         if (slot_tick && digit_idx == 3'd5) begin
            snap_sec <= sec_in;
            snap_min <= min_in;
            snap_hr  <= hr_in;
         end
      end
   end

   // cnt==0 marks the first cycle of a slot; blanking it hides the digit switch
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an  <= 6'b111111;
         seg <= 7'b1111111;
         dp  <= 1'b1;
      end else if (!en || cnt == '0) begin
         an  <= 6'b111111;
         seg <= 7'b1111111;
         dp  <= 1'b1;
      end else begin
         an  <= ~(6'b000001 << digit_idx);
         seg <= seg_d;
         dp  <= !(digit_idx == 3'd2 || digit_idx == 3'd4);
      end
   end
endmodule
